// File: rtl/dmem_responder.sv
// Data-memory slave for the processor dmem port: word-addressed RAM plus an
// MMIO page holding a free-running cycle counter, a byte output FIFO that
// drains over valid/ready, and a status register.
module dmem_responder #(
  parameter int          ADDR_BITS  = 12,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow
);

  localparam int DATA_W = 32;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic [DATA_W-1:0] ramMem [2**ADDR_BITS];
  logic [7:0]        fifoMem [FIFO_DEPTH];

  logic              isRam, isCycle, isOut, isStatus;
  logic              ramWe, pushReq, popReq, pushAccept, pushDrop, ovfClear;
  logic              fifoEmpty, fifoFull;
  logic [PTR_W-1:0]  headPtr, tailPtr;
  logic [CNT_W-1:0]  fifoCount;
  logic [DATA_W-1:0] cycleCount;
  logic [DATA_W-1:0] statusWord, mmioRd;
  logic [DATA_W-1:0] ramRd_p1, mmioRd_p1;
  logic              ramSel_p1;

  // Decode: RAM occupies the bottom of the word space, MMIO sits at MMIO_BASE.
  assign isRam    = (address_dmem >> ADDR_BITS) == '0;
  assign isCycle  = address_dmem == MMIO_BASE;
  assign isOut    = address_dmem == (MMIO_BASE + 32'd1);
  assign isStatus = address_dmem == (MMIO_BASE + 32'd2);

  // Writes that coincide with reset are dropped.
  assign ramWe    = wren && isRam && !reset;
  assign pushReq  = wren && isOut && !reset;
  assign ovfClear = wren && isStatus && data[2];

  assign fifoEmpty  = fifoCount == '0;
  assign fifoFull   = fifoCount == CNT_W'(FIFO_DEPTH);
  assign popReq     = !fifoEmpty && out_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign pushAccept = pushReq && (!fifoFull || popReq);
  assign pushDrop   = pushReq && fifoFull && !popReq;

  assign out_valid = !fifoEmpty;
  assign out_data  = fifoEmpty ? 8'h00 : fifoMem[headPtr];

  // Status layout: empty, full, overflow in the low bits, count from bit 4.
  always_comb begin
    statusWord              = '0;
    statusWord[0]           = fifoEmpty;
    statusWord[1]           = fifoFull;
    statusWord[2]           = overflow;
    statusWord[4 +: CNT_W]  = fifoCount;
  end

  // MMIO read mux; OUT and unmapped addresses read as zero.
  always_comb begin
    mmioRd = '0;
    if (isCycle)       mmioRd = cycleCount;
    else if (isStatus) mmioRd = statusWord;
  end

  // ---- stage p0 -> p1: synchronous RAM, read-before-write ----
  always_ff @(posedge clock) begin
    if (ramWe) ramMem[address_dmem[ADDR_BITS-1:0]] <= data;
    ramRd_p1 <= ramMem[address_dmem[ADDR_BITS-1:0]];
  end

  // Registered read-source select and MMIO read value.
  always_ff @(posedge clock) begin
    if (reset) begin
      ramSel_p1 <= 1'b0;
      mmioRd_p1 <= '0;
    end else begin
      ramSel_p1 <= isRam;
      mmioRd_p1 <= mmioRd;
    end
  end

  assign q_dmem = ramSel_p1 ? ramRd_p1 : mmioRd_p1;

  // Free-running cycle counter; a write reloads it and counting resumes from there.
  always_ff @(posedge clock) begin
    if (reset)                  cycleCount <= '0;
    else if (wren && isCycle)   cycleCount <= data;
    else                        cycleCount <= cycleCount + 32'd1;
  end

  // FIFO byte storage; written only on an accepted push.
  always_ff @(posedge clock) begin
    if (pushAccept) fifoMem[tailPtr] <= data[7:0];
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      headPtr   <= '0;
      tailPtr   <= '0;
      fifoCount <= '0;
    end else begin
      if (popReq)     headPtr <= headPtr + PTR_W'(1);
      if (pushAccept) tailPtr <= tailPtr + PTR_W'(1);
      fifoCount <= fifoCount + CNT_W'(pushAccept) - CNT_W'(popReq);
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clock) begin
    if (reset)         overflow <= 1'b0;
    else if (pushDrop) overflow <= 1'b1;
    else if (ovfClear) overflow <= 1'b0;
  end

endmodule
